// File: rtl/output_layer_seq.sv
// output_layer_seq: time-shared signed fixed-point MAC sequencer for the
// output layer; one saturated linear result per neuron on a valid/ready stream.
module output_layer_seq #(
    parameter int DWIDTH = 32,
    parameter int FRAC   = 24,
    parameter int NOUT   = 2,
    parameter int AW     = 8,
    parameter int BASE   = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DWIDTH-1:0] A,
    input  logic [DWIDTH-1:0] B,
    input  logic [DWIDTH-1:0] C,
    output logic              w_en,
    output logic [AW-1:0]     w_addr,
    input  logic [DWIDTH-1:0] w_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DWIDTH-1:0] out_data,
    output logic [5:0]        out_idx,
    output logic              out_last,
    output logic              out_sat,
    output logic              busy
);

    localparam int AWD = 2 * DWIDTH + 2;
    localparam logic [5:0] LASTN = 6'(NOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        RD,
        OUT
    } state_t;

    state_t state, state_nx;

    logic [DWIDTH-1:0] a_q, b_q, c_q;
    logic [5:0]        n_q;
    logic [2:0]        k_q;
    logic signed [AWD-1:0] acc_q;
    logic [DWIDTH-1:0] od_q;
    logic              sat_q;

    logic accept, xfer, is_last;

    logic signed [DWIDTH-1:0]   xop;
    logic signed [2*DWIDTH-1:0] prod;
    logic signed [AWD-1:0]      prod_x, bias_x, tot, sum;
    logic [AWD-DWIDTH:0]        hi;
    logic                       fits;
    logic [DWIDTH-1:0]          clamp;
    logic [AW-1:0]              addr;

    assign is_last = (n_q == LASTN);
    assign accept  = (state == IDLE) && in_valid;
    assign xfer    = (state == OUT) && out_ready;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    // Next state and state-decoded handshake/memory strobes
    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        w_en      = 1'b0;
        busy      = 1'b1;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (accept) state_nx = RD;
            end
            RD: begin
                w_en = (k_q <= 3'd3);
                if (k_q == 3'd4) state_nx = OUT;
            end
            OUT: begin
                out_valid = 1'b1;
                if (xfer) state_nx = is_last ? IDLE : RD;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Select the activation paired with the weight now on w_data
    always_comb begin
        xop = '0;
        unique case (1'b1)
            (k_q == 3'd1): xop = a_q;
            (k_q == 3'd2): xop = b_q;
            (k_q == 3'd3): xop = c_q;
            default:       xop = '0;
        endcase
    end

    assign prod   = $signed(w_data) * xop;
    assign prod_x = {{2{prod[2*DWIDTH-1]}}, prod};
    assign bias_x = {{(AWD-DWIDTH){w_data[DWIDTH-1]}}, w_data};
    assign tot    = acc_q + (bias_x <<< FRAC);
    assign sum    = tot >>> FRAC;
    assign hi     = sum[AWD-1:DWIDTH-1];
    assign fits   = (&hi) || !(|hi);
    assign clamp  = sum[AWD-1] ? {1'b1, {(DWIDTH-1){1'b0}}}
                               : {1'b0, {(DWIDTH-1){1'b1}}};

    assign addr   = AW'(BASE) + AW'({n_q, 2'b00}) + AW'(k_q);
    assign w_addr = w_en ? addr : '0;

    assign out_data = od_q;
    assign out_sat  = sat_q;
    assign out_idx  = n_q;
    assign out_last = (state == OUT) && is_last;

    // Operand latch, neuron/tap counters, accumulator and result register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_q   <= '0;
            b_q   <= '0;
            c_q   <= '0;
            n_q   <= '0;
            k_q   <= '0;
            acc_q <= '0;
            od_q  <= '0;
            sat_q <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        a_q   <= A;
                        b_q   <= B;
                        c_q   <= C;
                        n_q   <= '0;
                        k_q   <= '0;
                        acc_q <= '0;
                    end
                end
                RD: begin
                    if (k_q == 3'd4) begin
                        k_q   <= '0;
                        od_q  <= fits ? sum[DWIDTH-1:0] : clamp;
                        sat_q <= !fits;
                    end else begin
                        k_q <= k_q + 3'd1;
                        if (k_q != 3'd0) acc_q <= acc_q + prod_x;
                    end
                end
                OUT: begin
                    if (xfer && !is_last) begin
                        n_q   <= n_q + 6'd1;
                        k_q   <= '0;
                        acc_q <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_output_layer_seq.sv
// tb_output_layer_seq: randomized and directed checks of output_layer_seq
// against an arithmetic reference model and a synchronous weight memory.
module tb_output_layer_seq;

    localparam int DW   = 32;
    localparam int FRAC = 24;
    localparam int NOUT = 2;
    localparam int AW   = 8;
    localparam int BASE = 0;

    localparam logic signed [127:0] MAXV = (128'sd1 <<< 31) - 128'sd1;
    localparam logic signed [127:0] MINV = -(128'sd1 <<< 31);

    logic clk = 1'b0;
    logic rst;
    logic in_valid, in_ready;
    logic [DW-1:0] A, B, C;
    logic w_en;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_data;
    logic out_valid, out_ready;
    logic [DW-1:0] out_data;
    logic [5:0] out_idx;
    logic out_last, out_sat, busy;

    output_layer_seq #(
        .DWIDTH(DW), .FRAC(FRAC), .NOUT(NOUT), .AW(AW), .BASE(BASE)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .C(C),
        .w_en(w_en), .w_addr(w_addr), .w_data(w_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_idx(out_idx),
        .out_last(out_last), .out_sat(out_sat), .busy(busy)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [256];

    // Synchronous weight memory; garbage on w_data whenever not read
    always @(posedge clk) w_data <= w_en ? mem[w_addr] : $urandom;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [39:0] exp_q[$];
    logic [39:0] out_log[$];
    int acc_log[$];
    int last_log[$];
    logic [AW-1:0] addr_log[$];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference: exact sum of products, floor division by 2^FRAC, clamp
    function automatic logic [39:0] model(input int n,
                                          input logic [DW-1:0] a,
                                          input logic [DW-1:0] b,
                                          input logic [DW-1:0] c);
        logic signed [127:0] wa, wb, wc, bi, xa, xb, xc, s, q;
        logic [31:0] d;
        logic sat;
        wa = $signed(mem[BASE + 4 * n + 0]);
        wb = $signed(mem[BASE + 4 * n + 1]);
        wc = $signed(mem[BASE + 4 * n + 2]);
        bi = $signed(mem[BASE + 4 * n + 3]);
        xa = $signed(a);
        xb = $signed(b);
        xc = $signed(c);
        s = wa * xa + wb * xb + wc * xc + bi * (128'sd1 <<< FRAC);
        q = s >>> FRAC;
        sat = 1'b1;
        if (q > MAXV) d = 32'h7fffffff;
        else if (q < MINV) d = 32'h80000000;
        else begin
            d = q[31:0];
            sat = 1'b0;
        end
        return {sat, 1'(n == NOUT - 1), 6'(n), d};
    endfunction

    // Scoreboard bookkeeping on handshakes
    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            if (out_valid && out_ready) begin
                out_log.push_back({out_sat, out_last, out_idx, out_data});
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                if (out_last) last_log.push_back(cyc);
            end
            if (in_valid && in_ready) begin
                for (int n = 0; n < NOUT; n++)
                    exp_q.push_back(model(n, A, B, C));
                acc_log.push_back(cyc);
            end
        end
    end

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        if (!rst) begin
            chk("rst_wen", 64'(w_en), 64'd0);
            chk("rst_oval", 64'(out_valid), 64'd0);
            chk("rst_busy", 64'(busy), 64'd0);
        end else begin
            chk("ready_busy", 64'(in_ready), 64'(!busy));
            if (w_en) addr_log.push_back(w_addr);
            if (out_valid) begin
                chk("out_wen", 64'(w_en), 64'd0);
                if (exp_q.size() == 0)
                    chk("out_unexpected", 64'(out_valid), 64'd0);
                else
                    chk("out", 64'({out_sat, out_last, out_idx, out_data}),
                        64'(exp_q[0]));
            end
        end
    end

    task automatic set_neuron(input int n, input logic [31:0] wa,
                              input logic [31:0] wb, input logic [31:0] wc,
                              input logic [31:0] bi);
        mem[BASE + 4 * n + 0] = wa;
        mem[BASE + 4 * n + 1] = wb;
        mem[BASE + 4 * n + 2] = wc;
        mem[BASE + 4 * n + 3] = bi;
    endtask

    task automatic basic_mem();
        set_neuron(0, 32'h00800000, 32'h00400000, 32'h01000000, 32'h00200000);
        set_neuron(1, 32'h01000000, 32'h01000000, 32'h01000000, 32'h0);
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] c);
        int t = 0;
        A = a;
        B = b;
        C = c;
        in_valid = 1'b1;
        while (!in_ready && t < 500) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("send_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_outs(input int n, input bit rnd);
        int t = 0;
        while (out_log.size() < n && t < 2000) begin
            if (rnd) out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
            t++;
        end
        out_ready = 1'b1;
        chk("outs_count", 64'(out_log.size()), 64'(n));
    endtask

    function automatic logic [31:0] rw();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 2))
            0: return r;
            1: return {{7{r[24]}}, r[24:0]};
            default: return {{12{r[19]}}, r[19:0]};
        endcase
    endfunction

    initial begin
        int t;
        logic [39:0] snap;
        logic [31:0] v1a, v1b, v1c;
        rst = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        A = '0;
        B = '0;
        C = '0;
        for (int i = 0; i < 256; i++) mem[i] = '0;
        repeat (3) @(posedge clk);
        #1;

        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_w_en", 64'(w_en), 64'd0);
        chk("rst_w_addr", 64'(w_addr), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_idx", 64'(out_idx), 64'd0);
        chk("rst_out_last", 64'(out_last), 64'd0);
        chk("rst_out_sat", 64'(out_sat), 64'd0);
        chk("rst_busy_lvl", 64'(busy), 64'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        basic_mem();
        addr_log.delete();
        out_log.delete();
        acc_log.delete();
        last_log.delete();
        send(32'h01000000, 32'h02000000, 32'hFF000000);
        t = 0;
        while (!out_valid && t < 50) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("latency", 64'(t), 64'd5);
        wait_outs(2, 1'b0);
        chk("basic0", 64'(out_log[0]), 64'({2'b00, 6'd0, 32'h00200000}));
        chk("basic1", 64'(out_log[1]), 64'({2'b01, 6'd1, 32'h02000000}));
        chk("addr_cnt", 64'(addr_log.size()), 64'd8);
        for (int i = 0; i < 8; i++) chk("addr_seq", 64'(addr_log[i]), 64'(i));
        chk("vec_cycles", 64'(last_log[0] - acc_log[0]), 64'd12);

        set_neuron(0, 32'h02000000, 32'h0, 32'h0, 32'h0);
        set_neuron(1, 32'hFE000000, 32'h0, 32'h0, 32'h0);
        out_log.delete();
        send(32'h64000000, 32'h0, 32'h0);
        wait_outs(2, 1'b0);
        chk("sat_pos", 64'(out_log[0]), 64'({2'b10, 6'd0, 32'h7FFFFFFF}));
        chk("sat_neg", 64'(out_log[1]), 64'({2'b11, 6'd1, 32'h80000000}));

        set_neuron(0, 32'h00800000, 32'h0, 32'h0, 32'h0);
        set_neuron(1, 32'h0, 32'h0, 32'h0, 32'h0);
        out_log.delete();
        send(32'hFFFFFFFF, 32'h0, 32'h0);
        wait_outs(2, 1'b0);
        chk("floor0", 64'(out_log[0]), 64'({2'b00, 6'd0, 32'hFFFFFFFF}));
        chk("floor1", 64'(out_log[1]), 64'({2'b01, 6'd1, 32'h0}));

        basic_mem();
        out_log.delete();
        out_ready = 1'b0;
        send(32'h01000000, 32'h02000000, 32'hFF000000);
        t = 0;
        while (!out_valid && t < 50) begin
            @(posedge clk);
            #1;
            t++;
        end
        snap = {out_sat, out_last, out_idx, out_data};
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("bp_hold", 64'({out_sat, out_last, out_idx, out_data}),
                64'(snap));
            chk("bp_valid", 64'(out_valid), 64'd1);
            chk("bp_wen", 64'(w_en), 64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_resume_wen", 64'(w_en), 64'd1);
        chk("bp_resume_addr", 64'(w_addr), 64'd4);
        wait_outs(2, 1'b0);
        chk("bp0", 64'(out_log[0]), 64'({2'b00, 6'd0, 32'h00200000}));

        out_log.delete();
        acc_log.delete();
        last_log.delete();
        v1a = rw();
        v1b = rw();
        v1c = rw();
        A = v1a;
        B = v1b;
        C = v1c;
        in_valid = 1'b1;
        t = 0;
        while (!in_ready && t < 50) begin
            @(posedge clk);
            #1;
            t++;
        end
        @(posedge clk);
        #1;
        A = rw();
        B = rw();
        C = rw();
        t = 0;
        while (!in_ready && t < 100) begin
            @(posedge clk);
            #1;
            t++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_outs(4, 1'b0);
        chk("b2b_gap", 64'(acc_log[1] - last_log[0]), 64'd1);
        chk("b2b_v1", 64'(last_log[0] - acc_log[0]), 64'd12);
        chk("b2b_v2", 64'(last_log[1] - acc_log[1]), 64'd12);

        out_log.delete();
        send(32'h01000000, 32'h02000000, 32'hFF000000);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        #1;
        chk("mid_rst_wen", 64'(w_en), 64'd0);
        chk("mid_rst_oval", 64'(out_valid), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_ready", 64'(in_ready), 64'd1);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b1;
        out_log.delete();
        send(32'h01000000, 32'h02000000, 32'hFF000000);
        wait_outs(2, 1'b0);
        chk("post_rst0", 64'(out_log[0]), 64'({2'b00, 6'd0, 32'h00200000}));
        chk("post_rst1", 64'(out_log[1]), 64'({2'b01, 6'd1, 32'h02000000}));
        repeat (8) begin
            @(posedge clk);
            #1;
        end
        chk("no_stale", 64'(out_log.size()), 64'd2);

        for (int v = 0; v < 25; v++) begin
            for (int n = 0; n < NOUT; n++)
                set_neuron(n, rw(), rw(), rw(), rw());
            out_log.delete();
            send(rw(), rw(), rw());
            wait_outs(NOUT, 1'b1);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/output_layer_seq.md
# output_layer_seq

Sequencer for the network output layer that time-shares one signed fixed-point multiply-accumulate datapath across NOUT output neurons, each with 3 inputs. It latches a 3-value hidden-layer vector (A, B, C) through a valid/ready handshake. For each neuron it fetches wa, wb, wc and bias from a synchronous weight memory, then emits one linear (pre-activation), saturated result per neuron on a valid/ready output stream. It sits between the hidden layer and the classifier/readout logic, and replaces a fixed parallel bank of 3-input perceptrons with a configurable neuron count.

## Interface
- DWIDTH, 32, data word width (signed two's complement)
- FRAC, 24, fractional bits (Q8.24 at defaults)
- NOUT, 2, number of output neurons (1..64)
- AW, 8, weight memory address width
- BASE, 0, weight memory base address
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- in_valid  in  1  input vector valid
- in_ready  out  1  block can accept vector
- A, B, C  in  DWIDTH each  hidden-layer values, signed
- w_en  out  1  weight memory read enable
- w_addr  out  AW  weight memory address
- w_data  in  DWIDTH  read data, valid exactly 1 cycle after w_en
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_data  out  DWIDTH  neuron result, signed
- out_idx  out  6  neuron index of out_data
- out_last  out  1  out_data is neuron NOUT-1
- out_sat  out  1  result was clamped
- busy  out  1  state != IDLE

## Operation
- Memory layout: neuron n occupies BASE+4n+{0: wa, 1: wb, 2: wc, 3: bias}.
- States: IDLE, RD, OUT.
- IDLE: in_ready=1, which is combinational from state. A handshake (in_valid&&in_ready) latches A, B, C, sets n=0, k=0, clears acc, and goes to RD.
- RD, counter k=0..4:
  - For k=0..3: w_en=1 and w_addr=BASE+4n+k.
  - For k=1..3: acc += w_data * X(k-1), where X = A, B, C. Full 2*DWIDTH signed products; acc is 2*DWIDTH+2 bits.
  - At k=4, w_data is the bias. Register into out_data the value sum = (acc + (bias <<< FRAC)) >>> FRAC, using an arithmetic shift (floor). Go to OUT.
  - w_en=0 at k=4.
- Saturation: if sum > 2^(DWIDTH-1)-1, out_data = 0x7FFF_FFFF. If sum < -2^(DWIDTH-1), out_data = 0x8000_0000. out_sat=1 only when clamping occurs.
- OUT: out_valid=1. out_data, out_idx=n, out_last=(n==NOUT-1) and out_sat are held stable until transfer (out_valid&&out_ready).
  - On transfer with out_last: go to IDLE.
  - Otherwise: n++, k=0, clear acc, go to RD.
- While in OUT, w_en=0 and no memory reads are issued; backpressure stalls the whole sequence.
- Input is not accepted in RD or OUT. A new vector is accepted no earlier than the cycle after the last transfer.

## Timing
- Reset values: in_ready=1 (IDLE), w_en=0, w_addr=0, out_valid=0, out_data=0, out_idx=0, out_last=0, out_sat=0, busy=0. acc, n, k and the latched inputs are all 0.
- Reset asserted mid-operation clears state immediately (asynchronously). The partial result is discarded and no out_valid is produced.
- Input accepted at edge E0. Reads are issued in the cycles after E0, E1, E2 and E3. out_valid rises after E5, i.e. 5 cycles after acceptance.
- Per neuron with out_ready held high: 6 cycles. Full vector: 6*NOUT cycles from acceptance to the last transfer.
- w_data is sampled only in RD with k=1..4; it is ignored at all other times.

## Test plan
- Basic (Q8.24): A=0x01000000, B=0x02000000, C=0xFF000000. Neuron 0: wa=0x00800000, wb=0x00400000, wc=0x01000000, bias=0x00200000. Neuron 1: wa=wb=wc=0x01000000, bias=0.
  - Required: out_data=0x00200000 (idx 0), then 0x02000000 (idx 1, out_last=1).
  - out_valid first rises 5 cycles after acceptance; w_addr sequence 0..7.
- Saturation: A=0x64000000, wa=0x02000000, all other weights/bias 0. Required: out_data=0x7FFFFFFF, out_sat=1. Negated: 0x80000000, out_sat=1.
- Floor rounding: A=0xFFFFFFFF, wa=0x00800000, all others 0. Required: out_data=0xFFFFFFFF, out_sat=0.
- Backpressure: hold out_ready=0 for 3 cycles on neuron 0. Required: out_data, out_idx stable and w_en=0 throughout; neuron 1 reads start the cycle after the transfer.
- Back-to-back: in_valid held high with two vectors. Required: in_ready=0 while busy; second vector accepted the cycle after the out_last transfer; total 12 cycles per vector at NOUT=2.
- Reset mid-RD: assert rst=0 at k=2. Required: immediate w_en=0, out_valid=0, busy=0. After release the next vector produces correct results with no stale output.
